// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI mode-0 slave.
package spi_slave_pkg;

  // Transfer state, tracked on the synchronized chip select.
  typedef enum logic [1:0] {
    ST_WAIT,   // after reset: ignore the bus until CS_N is seen high
    ST_IDLE,   // deselected, armed for the next CS_N falling edge
    ST_ACTIVE  // selected, bits are being exchanged
  } spi_state_e;

  // Bit positions of the serial inputs in the synchronizer bundle.
  localparam int unsigned SYNC_W    = 3;
  localparam int unsigned SYNC_SCLK = 2;
  localparam int unsigned SYNC_CS_N = 1;
  localparam int unsigned SYNC_MOSI = 0;

endpackage

// File: rtl/spi_slave_sync_2ff.sv
// Two-flop synchronizer bundle for asynchronous single-bit inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture into the CLK domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversamples SCLK/CS_N/MOSI in the CLK domain,
// receives MSB-first words on DOUT and transmits DIN on MISO.
module spi_slave #(
  parameter int unsigned WORD_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SCLK,
  input  logic                  CS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [WORD_WIDTH-1:0] DIN,
  input  logic                  DIN_VLD,
  output logic                  DIN_RDY,
  output logic [WORD_WIDTH-1:0] DOUT,
  output logic                  DOUT_VLD
);

  import spi_slave_pkg::*;

  localparam int unsigned CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  logic [SYNC_W-1:0]     sync_s;
  logic                  sclk_s, cs_n_s, mosi_s;
  logic                  sclk_rise, sclk_fall, load;

  spi_state_e            state_q, state_d;
  logic                  sclk_prev_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] rx_q, rx_d;
  logic [WORD_WIDTH-1:0] tx_q, tx_d;
  logic                  loaded_q, loaded_d;
  logic [WORD_WIDTH-1:0] dout_q, dout_d;
  logic                  vld_q, vld_d;

  sync_2ff #(.WIDTH(SYNC_W)) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   ({SCLK, CS_N, MOSI}),
    .q_o   (sync_s)
  );

  assign sclk_s    = sync_s[SYNC_SCLK];
  assign cs_n_s    = sync_s[SYNC_CS_N];
  assign mosi_s    = sync_s[SYNC_MOSI];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign DIN_RDY  = ~RST & ~loaded_q & (cnt_q == '0);
  assign load     = DIN_VLD & DIN_RDY;
  assign MISO     = (state_q == ST_ACTIVE) & tx_q[WORD_WIDTH-1];
  assign DOUT     = dout_q;
  assign DOUT_VLD = vld_q;

  // State, shift registers and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_WAIT;
      sclk_prev_q <= 1'b0;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      loaded_q    <= 1'b0;
      dout_q      <= '0;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      loaded_q    <= loaded_d;
      dout_q      <= dout_d;
      vld_q       <= vld_d;
    end
  end

  // Next-state: word framing, RX/TX shifting and TX load.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    loaded_d = loaded_q;
    dout_d   = dout_q;
    vld_d    = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        cnt_d = '0;
        rx_d  = '0;
        if (cs_n_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        cnt_d = '0;
        rx_d  = '0;
        if (!cs_n_s) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (cs_n_s) begin
          // Deselect discards any partial word and the pending TX data.
          state_d = ST_IDLE;
          cnt_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
        end else if (sclk_rise) begin
          rx_d = {rx_q[WORD_WIDTH-2:0], mosi_s};
          if (cnt_q == '0) loaded_d = 1'b0;
          if (cnt_q == LAST_BIT) begin
            cnt_d  = '0;
            dout_d = {rx_q[WORD_WIDTH-2:0], mosi_s};
            vld_d  = 1'b1;
            tx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall && (cnt_q != '0)) begin
          // cnt_q == 0 here means the falling edge after the last bit.
          tx_d = {tx_q[WORD_WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // A load overrides the word-end / deselect clear in the same cycle.
    if (load) begin
      tx_d     = DIN;
      loaded_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of full-word transfers plus
// hand-written reset, abort, back-to-back and mid-word-reset sequences.
module tb_spi_slave;

  localparam int unsigned W = 64;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         SCLK = 1'b0;
  logic         CS_N = 1'b1;
  logic         MOSI = 1'b0;
  logic         MISO;
  logic [W-1:0] DIN = '0;
  logic         DIN_VLD = 1'b0;
  logic         DIN_RDY;
  logic [W-1:0] DOUT;
  logic         DOUT_VLD;

  spi_slave #(.WORD_WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SCLK     (SCLK),
    .CS_N     (CS_N),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .DIN      (DIN),
    .DIN_VLD  (DIN_VLD),
    .DIN_RDY  (DIN_RDY),
    .DOUT     (DOUT),
    .DOUT_VLD (DOUT_VLD)
  );

  always #10 CLK = ~CLK;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  int unsigned  vld_cnt = 0;
  logic [W-1:0] vld_log[$];
  logic [W-1:0] miso_cap = '0;

  typedef struct {
    logic [W-1:0] mosi;
    logic         do_load;
    logic [W-1:0] din;
    logic [W-1:0] exp_dout;
    logic [W-1:0] exp_miso;
  } vec_t;

  vec_t vecs[4];

  // Every cycle with DOUT_VLD high counts as one pulse; a stretched pulse
  // therefore shows up as an extra count.
  always @(negedge CLK) begin
    if (DOUT_VLD === 1'b1) begin
      vld_cnt++;
      vld_log.push_back(DOUT);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Master side of bits [first, last) of w, MSB first; MISO captured on rise.
  task automatic send_bits(input logic [W-1:0] w, input int unsigned first, input int unsigned last);
    for (int unsigned i = first; i < last; i++) begin
      MOSI = w[W-1-i];
      #160;
      SCLK = 1'b1;
      miso_cap = {miso_cap[W-2:0], MISO};
      #160;
      SCLK = 1'b0;
    end
  endtask

  task automatic load_word(input logic [W-1:0] d);
    int unsigned n;
    n = 0;
    @(negedge CLK);
    while (DIN_RDY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("din_rdy_before_load", W'(DIN_RDY), W'(1));
    DIN = d;
    DIN_VLD = 1'b1;
    @(negedge CLK);
    DIN_VLD = 1'b0;
    check("din_rdy_after_load", W'(DIN_RDY), W'(0));
  endtask

  task automatic settle();
    repeat (8) @(negedge CLK);
  endtask

  int unsigned base;

  initial begin
    vecs[0] = '{64'h1234_5678_9ABC_DEF0, 1'b1, 64'hA5A5_0000_FFFF_1234, 64'h1234_5678_9ABC_DEF0, 64'hA5A5_0000_FFFF_1234};
    vecs[1] = '{64'h0000_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{64'h8000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0000};
    vecs[3] = '{64'hC3C3_5A5A_0F0F_9669, 1'b1, 64'h8000_0000_0000_0001, 64'hC3C3_5A5A_0F0F_9669, 64'h8000_0000_0000_0001};

    // Reset state.
    repeat (5) @(negedge CLK);
    check("rst_dout", DOUT, '0);
    check("rst_dout_vld", W'(DOUT_VLD), W'(0));
    check("rst_miso", W'(MISO), W'(0));
    check("rst_din_rdy", W'(DIN_RDY), W'(0));
    RST = 1'b0;
    settle();

    // First word, no TX load: no early pulse, exactly one pulse, zeros on MISO.
    base = vld_cnt;
    miso_cap = '0;
    CS_N = 1'b0;
    #160;
    send_bits(64'h0100_0000_0000_0022, 0, 63);
    settle();
    check("no_vld_before_bit64", W'(vld_cnt - base), W'(0));
    send_bits(64'h0100_0000_0000_0022, 63, 64);
    settle();
    check("first_word_vld_count", W'(vld_cnt - base), W'(1));
    check("first_word_dout", DOUT, 64'h0100_0000_0000_0022);
    check("first_word_miso_zero", miso_cap, '0);
    CS_N = 1'b1;
    settle();

    // Table of full words; DIN_VLD is also pulsed mid-word and must be ignored.
    for (int unsigned v = 0; v < 4; v++) begin
      if (vecs[v].do_load) load_word(vecs[v].din);
      @(negedge CLK);
      base = vld_cnt;
      miso_cap = '0;
      CS_N = 1'b0;
      #160;
      send_bits(vecs[v].mosi, 0, 32);
      check("din_rdy_mid_word", W'(DIN_RDY), W'(0));
      DIN = 64'h5A5A_5A5A_5A5A_5A5A;
      DIN_VLD = 1'b1;
      @(negedge CLK);
      DIN_VLD = 1'b0;
      send_bits(vecs[v].mosi, 32, 64);
      #160;
      CS_N = 1'b1;
      settle();
      check("vec_vld_count", W'(vld_cnt - base), W'(1));
      check("vec_dout", DOUT, vecs[v].exp_dout);
      check("vec_miso", miso_cap, vecs[v].exp_miso);
      check("vec_din_rdy_after", W'(DIN_RDY), W'(1));
    end

    // Aborted word after 20 bits: no pulse, DOUT kept; then a full word.
    base = vld_cnt;
    CS_N = 1'b0;
    #160;
    send_bits(64'h0F0F_0F0F_0F0F_0F0F, 0, 20);
    #160;
    CS_N = 1'b1;
    settle();
    check("abort_no_vld", W'(vld_cnt - base), W'(0));
    check("abort_dout_kept", DOUT, vecs[3].exp_dout);
    CS_N = 1'b0;
    #160;
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 0, 64);
    settle();
    check("after_abort_vld", W'(vld_cnt - base), W'(1));
    check("after_abort_dout", DOUT, 64'hFFFF_FFFF_FFFF_FFFF);
    CS_N = 1'b1;
    settle();

    // Two back-to-back words with CS_N held low, TX reloaded between them.
    load_word(64'h0123_4567_89AB_CDEF);
    @(negedge CLK);
    base = vld_cnt;
    vld_log.delete();
    miso_cap = '0;
    CS_N = 1'b0;
    #160;
    send_bits(64'hDEAD_BEEF_0123_4567, 0, 64);
    check("b2b_miso_1", miso_cap, 64'h0123_4567_89AB_CDEF);
    load_word(64'h5555_AAAA_0000_FFFF);
    miso_cap = '0;
    send_bits(64'h0F0F_F0F0_3C3C_C3C3, 0, 64);
    check("b2b_miso_2", miso_cap, 64'h5555_AAAA_0000_FFFF);
    settle();
    check("b2b_vld_count", W'(vld_cnt - base), W'(2));
    if (vld_log.size() >= 2) begin
      check("b2b_dout_1", vld_log[0], 64'hDEAD_BEEF_0123_4567);
      check("b2b_dout_2", vld_log[1], 64'h0F0F_F0F0_3C3C_C3C3);
    end else begin
      check("b2b_log_size", W'(vld_log.size()), W'(2));
    end
    CS_N = 1'b1;
    settle();

    // Reset mid-word with a loaded all-ones TX word driving MISO high.
    load_word(64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge CLK);
    CS_N = 1'b0;
    #160;
    send_bits(64'hAAAA_AAAA_AAAA_AAAA, 0, 30);
    check("pre_reset_miso", W'(MISO), W'(1));
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_reset_dout", DOUT, '0);
    check("mid_reset_dout_vld", W'(DOUT_VLD), W'(0));
    check("mid_reset_miso", W'(MISO), W'(0));
    check("mid_reset_din_rdy", W'(DIN_RDY), W'(0));
    @(negedge CLK);
    RST = 1'b0;
    base = vld_cnt;
    // CS_N never rose, so these bits must all be ignored.
    send_bits(64'hAAAA_AAAA_AAAA_AAAA, 30, 64);
    send_bits(64'h1111_2222_3333_4444, 0, 64);
    settle();
    check("post_reset_ignored_vld", W'(vld_cnt - base), W'(0));
    check("post_reset_ignored_dout", DOUT, '0);
    #160;
    CS_N = 1'b1;
    settle();
    miso_cap = '0;
    CS_N = 1'b0;
    #160;
    send_bits(64'h0123_4567_89AB_CDEF, 0, 64);
    settle();
    check("post_reset_vld", W'(vld_cnt - base), W'(1));
    check("post_reset_dout", DOUT, 64'h0123_4567_89AB_CDEF);
    check("post_reset_miso_zero", miso_cap, '0);
    CS_N = 1'b1;
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter WORD_WIDTH, default 64: bits per SPI word and width of DIN/DOUT.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  system clock; all logic synchronous to its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 SCLK  input  1  SPI serial clock from master; asynchronous to CLK.
REQ-006 CS_N  input  1  SPI chip select, active low; asynchronous to CLK.
REQ-007 MOSI  input  1  master-out serial data, MSB first.
REQ-008 MISO  output  1  slave-out serial data, MSB first; always driven, never tri-stated.
REQ-009 DIN  input  WORD_WIDTH  word to transmit on MISO.
REQ-010 DIN_VLD  input  1  DIN valid; transfer occurs when DIN_VLD and DIN_RDY are both high on a CLK edge.
REQ-011 DIN_RDY  output  1  slave can accept a TX word.
REQ-012 DOUT  output  WORD_WIDTH  last complete received word.
REQ-013 DOUT_VLD  output  1  one-CLK pulse when DOUT is updated.

Function
REQ-014 SPI mode 0 (CPOL=0, CPHA=0): sample MOSI on SCLK rising edge; update MISO on SCLK falling edge.
REQ-015 SCLK, CS_N and MOSI: each passes through a 2-flop synchronizer into CLK domain; edges detected from synchronized SCLK (current vs previous).
REQ-016 Required SCLK timing: high and low phases each at least 4 CLK periods; faster SCLK is unsupported.
REQ-017 Bit counter: 0..WORD_WIDTH-1.
  - Increments on each sampled rising SCLK edge while CS_N is low.
  - Wraps to 0 after bit WORD_WIDTH-1.
REQ-018 RX shift register: shifts left with the MOSI bit entering the LSB; first received bit becomes DOUT[WORD_WIDTH-1].
REQ-019 On the rising edge carrying bit WORD_WIDTH-1:
  - DOUT loads the full word on the next CLK edge.
  - DOUT_VLD is high for exactly that one cycle.
  - DOUT holds until the next complete word.
REQ-020 Consecutive words with CS_N held low are supported; each completed word produces its own DOUT_VLD pulse.
REQ-021 CS_N high (synchronized): bit counter and RX shift register clear, no DOUT_VLD; a partial word is discarded.
REQ-022 TX register load: on DIN_VLD && DIN_RDY, the TX shift register loads DIN and a tx_loaded flag sets.
REQ-023 DIN_RDY = not RST, not tx_loaded, and bit counter = 0.
REQ-024 tx_loaded clears at the first rising SCLK edge of a word.
REQ-025 MISO = TX shift register MSB while CS_N is low; 0 while CS_N is high.
REQ-026 TX shift register: shifts left (zero fill) on each falling SCLK edge within a word; no shift on the falling edge after the final bit.
REQ-027 If no word is loaded before a word starts, zeros are transmitted.
REQ-028 TX register clears at word end or when CS_N goes high, unless a load occurs in the same cycle (load wins).
REQ-029 DIN_VLD while DIN_RDY is low: ignored, no side effect.

Reset
REQ-030 While RST is high on a CLK edge:
  - Synchronizers, counter, shift registers and tx_loaded clear.
  - DOUT = 0, DOUT_VLD = 0, MISO = 0, DIN_RDY = 0.
REQ-031 Reset mid-word aborts the transfer; after release the slave waits for CS_N high-to-low before accepting bits.

Structure
REQ-032 No shared package required; WORD_WIDTH is a module parameter.
REQ-033 One sub-module: sync_2ff (parameterizable-width 2-flop synchronizer), instantiated for SCLK/CS_N/MOSI.

Verification
REQ-034 Reset 100 ns, then CS_N low and 64 bits of 0x0100000000000022 MSB first (20 ns CLK, 160 ns SCLK half-period):
  - DOUT = 0x0100000000000022.
  - Exactly one DOUT_VLD pulse.
  - No pulse before bit 64.
REQ-035 Load DIN = 0xA5A5_0000_FFFF_1234 while idle, then a 64-bit transfer:
  - MISO captured on master rising edges equals 0xA5A5_0000_FFFF_1234.
  - DIN_RDY low during the word, high after.
REQ-036 Transfer with no DIN load -> MISO all zeros; DOUT still receives MOSI data correctly.
REQ-037 CS_N raised after 20 bits -> no DOUT_VLD, DOUT unchanged; next full word 0xFFFF_FFFF_FFFF_FFFF is received correctly.
REQ-038 Two back-to-back words with CS_N held low -> two DOUT_VLD pulses with correct values.
REQ-039 RST asserted mid-word -> all outputs 0 next cycle; a subsequent full word is received correctly.
